// File: rtl/ps2_receiver.sv
// ps2_receiver: turns the raw PS/2 keyboard clock/data pins into 8-bit scan
// codes. Synchronizes both lines, glitch-filters the clock and detects its
// falling edges. Frames are {start, 8 data LSB first, parity, stop}.
// Good frames update code_out and strobe code_valid_out for one cycle.
// Bad frames and stalled frames strobe frame_err_out instead.
// Optional feature macro: PS2_PARITY_CHECK_EN. When it is defined, odd parity
// is enforced. When it is undefined, the parity bit is latched and ignored.
//
// Output handshake: there is no backpressure. code_valid_out and
// frame_err_out are single-cycle strobes that are never high together. The
// consumer must take every strobe in the cycle it appears. code_out holds its
// value until the next good frame.

module ps2_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] code_out,
    output logic       code_valid_out,
    output logic       frame_err_out
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Synchronizer chains; bit 0 faces the pin.
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   ps2_clk_s, ps2_data_s;

    // Glitch filter and falling-edge detector.
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              filt_clk_q, filt_clk_d;
    logic              filt_prev_q, filt_prev_d;
    logic              fall_stb;

    // Frame state (state_q is the FSM state; probe it hierarchically).
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic        to_hit;
    logic        parity_ok;

    // Outputs.
    logic [7:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall_stb   = filt_prev_q & ~filt_clk_q;

    // A stall is declared only mid-frame. A coinciding edge takes priority.
    assign to_hit = (state_q != ST_IDLE) && !fall_stb &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity across the 8 data bits plus the parity bit.
    assign parity_ok = ^{shift_q, parity_q};
`else
    // The parity bit is kept but does not gate acceptance.
    assign parity_ok = 1'b1 | parity_q;
`endif

    // Synchronizer shift and glitch filter: flip level after FILTER_LEN differing samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
        filt_cnt_d  = '0;
        filt_clk_d  = filt_clk_q;
        filt_prev_d = filt_clk_q;
        if (ps2_clk_s != filt_clk_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_clk_d = ps2_clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // State register plus all datapath and output flops.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_clk_q  <= filt_clk_d;
            filt_prev_q <= filt_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: advances only on a filtered falling edge, or aborts on stall.
    always_comb begin
        state_d = state_q;
        if (fall_stb) begin
            case (state_q)
                ST_IDLE:   if (!ps2_data_s) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end else if (to_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Output and datapath logic: shifting, bit counting, stall timer and strobes.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (fall_stb || (state_q == ST_IDLE) || to_hit) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (fall_stb) begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = '0;
                    if (ps2_data_s) err_d = 1'b1;
                end
                ST_DATA: begin
                    shift_d   = {ps2_data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                ST_PARITY: parity_d = ps2_data_s;
                ST_STOP: begin
                    if (ps2_data_s && parity_ok) begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (to_hit) begin
            err_d = 1'b1;
        end
    end

    assign code_out       = code_q;
    assign code_valid_out = valid_q;
    assign frame_err_out  = err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver. The stimulus pushes each expected
// outcome into exp_q. The encoding is {kind[1:0], code[7:0]}, where kind
// 0 is a good code, 1 is a frame error and 2 is a timeout error. A monitor
// pops one entry for every strobe and compares it with the strobe.

module tb_ps2_receiver;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       valid;
  logic       err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  logic [7:0] last_code = 8'h00;
  logic [9:0] exp_q[$];

  ps2_receiver #(
    .SYNC_STAGES(2),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .ps2_clk_in(ps2_clk),
    .ps2_data_in(ps2_data),
    .code_out(code),
    .code_valid_out(valid),
    .frame_err_out(err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(HALF / 2 - FILTER_LEN);
      ps2_clk = 1'b0;
      wait_cyc(FILTER_LEN - 1);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(par, 1'b0);
    send_bit(stop, 1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    wait_cyc(200);
  endtask

  task automatic send_good(input logic [7:0] d, input bit glitch);
    exp_q.push_back({2'b00, d});
    send_frame(d, ~^d, 1'b1, glitch);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic check_code(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h", name, act, req);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [9:0] e;
    logic prev_valid;
    int lat;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (valid === 1'b1 || err === 1'b1)) begin
        checks++;
        if (valid && err) begin
          failures++;
          $display("FAIL both_strobes valid=%b err=%b required one only", valid, err);
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe valid=%b err=%b code=%02h required none", valid, err, code);
        end else begin
          e = exp_q.pop_front();
          if (e[9:8] == 2'b00) begin
            check_bit("valid_strobe", valid, 1'b1);
            check_code("valid_code", code, e[7:0]);
            check_bit("valid_one_cycle_prev", prev_valid, 1'b0);
            last_code = e[7:0];
          end else begin
            check_bit("err_strobe", err, 1'b1);
            check_code("err_code_held", code, last_code);
            if (e[9:8] == 2'b10) begin
              lat = cyc - last_fall_cyc;
              checks++;
              if (lat < TIMEOUT_CYCLES || lat > TIMEOUT_CYCLES + 12) begin
                failures++;
                $display("FAIL timeout_latency actual=%0d required=%0d..%0d", lat,
                         TIMEOUT_CYCLES, TIMEOUT_CYCLES + 12);
              end
            end
          end
        end
      end
      prev_valid = (valid === 1'b1);
    end
  end

  // main stimulus
  initial begin
    logic [7:0] tb_byte;
    wait_cyc(5);
    check_code("reset_code", code, 8'h00);
    check_bit("reset_valid", valid, 1'b0);
    check_bit("reset_err", err, 1'b0);
    rst = 1'b0;
    wait_cyc(20);

    // single frame and back-to-back frames
    send_good(8'h1D, 1'b0);
    send_good(8'hE0, 1'b0);
    send_good(8'hF0, 1'b0);
    send_good(8'h75, 1'b0);

    // bad stop bit, then recovery
    exp_q.push_back({2'b01, 8'h00});
    send_frame(8'h1C, ~^8'h1C, 1'b0, 1'b0);
    send_good(8'h23, 1'b0);

    // wrong parity
`ifdef PS2_PARITY_CHECK_EN
    exp_q.push_back({2'b01, 8'h00});
`else
    exp_q.push_back({2'b00, 8'h1D});
`endif
    send_frame(8'h1D, 1'b0, 1'b1, 1'b0);

    // stalled frame: start plus 4 data bits, then clock held high
    exp_q.push_back({2'b10, 8'h00});
    tb_byte = 8'hA5;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(tb_byte[i], 1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT_CYCLES + 100);
    send_good(8'h1B, 1'b0);

    // short clock glitches during every data bit
    send_good(8'h5A, 1'b1);

    // reset in the middle of a frame
    tb_byte = 8'h66;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(tb_byte[i], 1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    rst = 1'b1;
    wait_cyc(3);
    check_code("midreset_code", code, 8'h00);
    check_bit("midreset_valid", valid, 1'b0);
    check_bit("midreset_err", err, 1'b0);
    last_code = 8'h00;
    rst = 1'b0;
    wait_cyc(20);
    send_good(8'h34, 1'b0);

    wait_cyc(50);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
